// File: rtl/axis_upsize_pkt_if.sv
// rtl/axis_upsize_pkt_if.sv - AXI4-Stream bundle (tvalid/tready/tdata/tkeep/tlast) for the upsizer ports
interface axis_upsize_pkt_if #(
    parameter int W = 32
) ();
    logic           tvalid;
    logic           tready;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tkeep;
    logic           tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axis_upsize_pkt.sv
// rtl/axis_upsize_pkt.sv - AXI4-Stream width upsizer packing RATIO narrow beats into one wide beat
// A tlast before the word is full flushes a short word with unfilled lanes zeroed.
module axis_upsize_pkt #(
    parameter int IN_W      = 32,
    parameter int RATIO     = 2,
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    axis_upsize_pkt_if.slave  s_axis,
    axis_upsize_pkt_if.master m_axis,
    output logic [CNT_W-1:0]  partial_cnt
);
    localparam int OUT_W  = IN_W * RATIO;
    localparam int KIN_W  = IN_W / 8;
    localparam int KOUT_W = OUT_W / 8;
    localparam int LW     = $clog2(RATIO);
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    // Assembly storage is indexed by beat order, not by output slot.
    logic [LW-1:0]              r_lane;
    logic [(RATIO-1)*IN_W-1:0]  r_asm_data;
    logic [(RATIO-1)*KIN_W-1:0] r_asm_keep;
    logic                       r_m_valid;
    logic [OUT_W-1:0]           r_m_data;
    logic [KOUT_W-1:0]          r_m_keep;
    logic                       r_m_last;
    logic [CNT_W-1:0]           r_partial_cnt;

    logic              w_s_ready;
    logic              w_accept;
    logic              w_complete;
    logic              w_partial;
    logic [OUT_W-1:0]  w_merge_data;
    logic [KOUT_W-1:0] w_merge_keep;

    function automatic int slot(input int k);
        return LSB_FIRST ? k : (RATIO - 1 - k);
    endfunction

    assign w_s_ready  = aresetn & (~r_m_valid | m_axis.tready);
    assign w_accept   = s_axis.tvalid & w_s_ready;
    assign w_complete = w_accept & ((r_lane == LAST_LANE) | s_axis.tlast);
    assign w_partial  = w_accept & s_axis.tlast & (r_lane != LAST_LANE);

    always_comb begin
        w_merge_data = '0;
        w_merge_keep = '0;
        for (int k = 0; k < RATIO - 1; k++) begin
            if (k < int'(r_lane)) begin
                w_merge_data[slot(k)*IN_W +: IN_W]   = r_asm_data[k*IN_W +: IN_W];
                w_merge_keep[slot(k)*KIN_W +: KIN_W] = r_asm_keep[k*KIN_W +: KIN_W];
            end
        end
        for (int k = 0; k < RATIO; k++) begin
            if (k == int'(r_lane)) begin
                w_merge_data[slot(k)*IN_W +: IN_W]   = s_axis.tdata;
                w_merge_keep[slot(k)*KIN_W +: KIN_W] = s_axis.tkeep;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_lane        <= '0;
            r_asm_data    <= '0;
            r_asm_keep    <= '0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_keep      <= '0;
            r_m_last      <= 1'b0;
            r_partial_cnt <= '0;
        end else begin
            if (w_complete) begin
                r_lane     <= '0;
                r_asm_keep <= '0;
            end else if (w_accept) begin
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (r_lane == LW'(k)) begin
                        r_asm_data[k*IN_W +: IN_W]   <= s_axis.tdata;
                        r_asm_keep[k*KIN_W +: KIN_W] <= s_axis.tkeep;
                    end
                end
                r_lane <= r_lane + LW'(1);
            end

            // A completing beat can only be accepted when the output slot is free or draining.
            if (w_complete) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_merge_data;
                r_m_keep  <= w_merge_keep;
                r_m_last  <= s_axis.tlast;
            end else if (m_axis.tready) begin
                r_m_valid <= 1'b0;
            end

            if (w_partial && (r_partial_cnt != '1)) begin
                r_partial_cnt <= r_partial_cnt + CNT_W'(1);
            end
        end
    end

    assign s_axis.tready = w_s_ready;
    assign m_axis.tvalid = r_m_valid;
    assign m_axis.tdata  = r_m_data;
    assign m_axis.tkeep  = r_m_keep;
    assign m_axis.tlast  = r_m_last;
    assign partial_cnt   = r_partial_cnt;
endmodule

// File: tb/tb_axis_upsize_pkt.sv
// tb/tb_axis_upsize_pkt.sv - directed and table-driven bench for axis_upsize_pkt in three configurations
module tb_axis_upsize_pkt;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axis_upsize_pkt_if #(.W(32))  s0 ();
    axis_upsize_pkt_if #(.W(64))  m0 ();
    axis_upsize_pkt_if #(.W(32))  s1 ();
    axis_upsize_pkt_if #(.W(128)) m1 ();
    axis_upsize_pkt_if #(.W(32))  s2 ();
    axis_upsize_pkt_if #(.W(64))  m2 ();
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    logic [15:0] cnt2;

    axis_upsize_pkt #(.IN_W(32), .RATIO(2), .LSB_FIRST(1'b1), .CNT_W(16)) u0 (
        .aclk(aclk), .aresetn(aresetn), .s_axis(s0), .m_axis(m0), .partial_cnt(cnt0));
    axis_upsize_pkt #(.IN_W(32), .RATIO(4), .LSB_FIRST(1'b1), .CNT_W(4)) u1 (
        .aclk(aclk), .aresetn(aresetn), .s_axis(s1), .m_axis(m1), .partial_cnt(cnt1));
    axis_upsize_pkt #(.IN_W(32), .RATIO(2), .LSB_FIRST(1'b0), .CNT_W(16)) u2 (
        .aclk(aclk), .aresetn(aresetn), .s_axis(s2), .m_axis(m2), .partial_cnt(cnt2));

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        ev;
        logic [63:0] ed;
        logic [7:0]  ek;
        logic        el;
        logic [15:0] ec;
    } vec_t;

    vec_t vt[6];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send0(input logic [31:0] d, input logic [3:0] k, input logic l);
        s0.tvalid = 1'b1; s0.tdata = d; s0.tkeep = k; s0.tlast = l;
        tick();
        s0.tvalid = 1'b0;
    endtask

    task automatic send1(input logic [31:0] d, input logic [3:0] k, input logic l);
        s1.tvalid = 1'b1; s1.tdata = d; s1.tkeep = k; s1.tlast = l;
        tick();
        s1.tvalid = 1'b0;
    endtask

    task automatic send2(input logic [31:0] d, input logic [3:0] k, input logic l);
        s2.tvalid = 1'b1; s2.tdata = d; s2.tkeep = k; s2.tlast = l;
        tick();
        s2.tvalid = 1'b0;
    endtask

    logic [63:0] qd[$];
    logic [7:0]  qk[$];
    logic        ql[$];

    initial begin
        int words, stalls, sent, pushed, got, cyc;
        logic        mlane, acc_s, acc_m, stall;
        logic [31:0] ad, bd;
        logic [3:0]  ak, bk;
        logic        bl;
        logic [63:0] hd, ed;
        logic [7:0]  hk, ek;
        logic        hl, el;

        s0.tvalid = 1'b0; s0.tdata = '0; s0.tkeep = '0; s0.tlast = 1'b0; m0.tready = 1'b1;
        s1.tvalid = 1'b0; s1.tdata = '0; s1.tkeep = '0; s1.tlast = 1'b0; m1.tready = 1'b1;
        s2.tvalid = 1'b0; s2.tdata = '0; s2.tkeep = '0; s2.tlast = 1'b0; m2.tready = 1'b1;

        vt[0] = '{32'hA0A0A0A0, 4'hF, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 16'd0};
        vt[1] = '{32'hB1B1B1B1, 4'hF, 1'b1, 1'b1, 64'hB1B1B1B1_A0A0A0A0, 8'hFF, 1'b1, 16'd0};
        vt[2] = '{32'h11111111, 4'h3, 1'b1, 1'b1, 64'h00000000_11111111, 8'h03, 1'b1, 16'd1};
        vt[3] = '{32'h22222222, 4'hF, 1'b0, 1'b0, 64'h0, 8'h00, 1'b0, 16'd1};
        vt[4] = '{32'h33333333, 4'h0, 1'b0, 1'b1, 64'h33333333_22222222, 8'h0F, 1'b0, 16'd1};
        vt[5] = '{32'h44444444, 4'hC, 1'b1, 1'b1, 64'h00000000_44444444, 8'h0C, 1'b1, 16'd2};

        // Reset state
        tick(); tick();
        chk("rst_m_valid", m0.tvalid, 1'b0);
        chk("rst_m_data", m0.tdata, 64'h0);
        chk("rst_m_keep", m0.tkeep, 8'h0);
        chk("rst_m_last", m0.tlast, 1'b0);
        chk("rst_cnt", cnt0, 16'h0);
        chk("rst_s_ready", s0.tready, 1'b0);
        aresetn = 1'b1;
        #1;
        chk("rel_s_ready", s0.tready, 1'b1);

        // Table on RATIO=2, LSB_FIRST=1
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("tbl%0d_s_ready", i), s0.tready, 1'b1);
            send0(vt[i].d, vt[i].k, vt[i].l);
            chk($sformatf("tbl%0d_valid", i), m0.tvalid, vt[i].ev);
            if (vt[i].ev) begin
                chk($sformatf("tbl%0d_data", i), m0.tdata, vt[i].ed);
                chk($sformatf("tbl%0d_keep", i), m0.tkeep, vt[i].ek);
                chk($sformatf("tbl%0d_last", i), m0.tlast, vt[i].el);
            end
            chk($sformatf("tbl%0d_cnt", i), cnt0, vt[i].ec);
        end
        tick();
        chk("tbl_drained", m0.tvalid, 1'b0);

        // RATIO=4 partial flush, then counter saturation
        send1(32'h11111111, 4'hF, 1'b0);
        send1(32'h22222222, 4'hF, 1'b0);
        chk("t2_no_early", m1.tvalid, 1'b0);
        send1(32'h33333333, 4'hF, 1'b1);
        chk("t2_valid", m1.tvalid, 1'b1);
        chk("t2_data", m1.tdata, 128'h00000000_33333333_22222222_11111111);
        chk("t2_keep", m1.tkeep, 16'h0FFF);
        chk("t2_last", m1.tlast, 1'b1);
        chk("t2_cnt", cnt1, 4'd1);
        for (int i = 0; i < 19; i++) begin
            send1(32'h5A5A0000 + 32'(i), 4'h1, 1'b1);
            if (i == 0) begin
                chk("sat_word_data", m1.tdata, {96'h0, 32'h5A5A0000});
                chk("sat_word_keep", m1.tkeep, 16'h0001);
            end
            if (i == 12) chk("sat_cnt_14", cnt1, 4'hE);
            if (i == 13) chk("sat_cnt_15", cnt1, 4'hF);
        end
        chk("sat_cnt_hold", cnt1, 4'hF);

        // LSB_FIRST=0 lane order
        send2(32'hAAAAAAAA, 4'hF, 1'b0);
        send2(32'hBBBBBBBB, 4'hF, 1'b1);
        chk("t5_valid", m2.tvalid, 1'b1);
        chk("t5_data", m2.tdata, 64'hAAAAAAAA_BBBBBBBB);
        chk("t5_keep", m2.tkeep, 8'hFF);
        send2(32'hCCCCCCCC, 4'h7, 1'b1);
        chk("t5p_data", m2.tdata, 64'hCCCCCCCC_00000000);
        chk("t5p_keep", m2.tkeep, 8'h70);
        chk("t5p_cnt", cnt2, 16'd1);

        // Streaming with constant downstream ready
        words = 0;
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            s0.tvalid = 1'b1;
            s0.tdata  = 32'h10000000 + 32'(i);
            s0.tkeep  = 4'hF;
            s0.tlast  = ((i % 8) == 7);
            if (!s0.tready) stalls++;
            tick();
            if (i == 0) chk("t3_valid_after_1", m0.tvalid, 1'b0);
            if (i == 1) chk("t3_valid_after_2", m0.tvalid, 1'b1);
            if (m0.tvalid) begin
                words++;
                chk($sformatf("t3_data_%0d", i), m0.tdata,
                    {32'h10000000 + 32'(i), 32'h10000000 + 32'(i - 1)});
                chk($sformatf("t3_last_%0d", i), m0.tlast, ((i % 8) == 7));
            end
        end
        s0.tvalid = 1'b0;
        s0.tlast  = 1'b0;
        tick();
        chk("t3_stalls", 128'(stalls), 128'd0);
        chk("t3_words", 128'(words), 128'd32);

        // Random backpressure with scoreboard
        sent = 0; pushed = 0; got = 0; cyc = 0; mlane = 1'b0;
        ad = '0; ak = '0;
        while ((sent < 200 || qd.size() > 0 || m0.tvalid) && cyc < 4000) begin
            cyc++;
            m0.tready = 1'($urandom_range(0, 1));
            if (!s0.tvalid && sent < 200 && $urandom_range(0, 3) != 0) begin
                s0.tvalid = 1'b1;
                s0.tdata  = $urandom;
                s0.tkeep  = 4'($urandom_range(0, 15));
                s0.tlast  = ($urandom_range(0, 3) == 0) || (sent == 199);
            end
            #1;
            acc_s = s0.tvalid & s0.tready;
            acc_m = m0.tvalid & m0.tready;
            stall = m0.tvalid & ~m0.tready;
            bd = s0.tdata; bk = s0.tkeep; bl = s0.tlast;
            hd = m0.tdata; hk = m0.tkeep; hl = m0.tlast;
            if (acc_m) begin
                got++;
                if (qd.size() == 0) begin
                    chk("t4_unexpected_word", 1'b1, 1'b0);
                end else begin
                    ed = qd.pop_front(); ek = qk.pop_front(); el = ql.pop_front();
                    chk("t4_data", hd, ed);
                    chk("t4_keep", hk, ek);
                    chk("t4_last", hl, el);
                end
            end
            tick();
            if (stall) begin
                chk("t4_hold_valid", m0.tvalid, 1'b1);
                chk("t4_hold_word", {m0.tlast, m0.tkeep, m0.tdata}, {hl, hk, hd});
            end
            if (acc_s) begin
                sent++;
                s0.tvalid = 1'b0;
                if (!mlane) begin
                    if (bl) begin
                        qd.push_back({32'h0, bd}); qk.push_back({4'h0, bk}); ql.push_back(1'b1);
                        pushed++;
                    end else begin
                        ad = bd; ak = bk; mlane = 1'b1;
                    end
                end else begin
                    qd.push_back({bd, ad}); qk.push_back({bk, ak}); ql.push_back(bl);
                    pushed++;
                    mlane = 1'b0;
                end
            end
        end
        chk("t4_timeout", 128'(cyc < 4000), 128'd1);
        chk("t4_word_count", 128'(got), 128'(pushed));
        m0.tready = 1'b1;
        s0.tvalid = 1'b0;
        s0.tlast  = 1'b0;
        tick();

        // Reset in the middle of a word
        send0(32'hDEADBEEF, 4'hF, 1'b0);
        #3;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_s_ready", s0.tready, 1'b0);
        chk("t6_rst_m_valid", m0.tvalid, 1'b0);
        tick();
        aresetn = 1'b1;
        tick();
        chk("t6_no_output", m0.tvalid, 1'b0);
        send0(32'hC0C0C0C0, 4'hF, 1'b0);
        chk("t6_no_early", m0.tvalid, 1'b0);
        send0(32'hD1D1D1D1, 4'hF, 1'b1);
        chk("t6_valid", m0.tvalid, 1'b1);
        chk("t6_data", m0.tdata, 64'hD1D1D1D1_C0C0C0C0);
        chk("t6_keep", m0.tkeep, 8'hFF);
        chk("t6_last", m0.tlast, 1'b1);
        chk("t6_cnt", cnt0, 16'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
